// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: line-clear FSM states, scoring constants, default board size.
package tetris_pkg;

    localparam int unsigned DEFAULT_ROWS = 20;
    localparam int unsigned DEFAULT_COLS = 10;

    localparam int unsigned PTS_1 = 40;
    localparam int unsigned PTS_2 = 100;
    localparam int unsigned PTS_3 = 300;
    localparam int unsigned PTS_4 = 1200;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        FILL  = 3'd2,
        SCORE = 3'd3,
        DONE  = 3'd4
    } lc_state_t;

    // Base points for n lines cleared in one evaluation (four or more pay as a tetris).
    function automatic logic [10:0] base_points(input int unsigned n);
        logic [10:0] pts;
        pts = 11'd0;
        if (n == 1)      pts = 11'(PTS_1);
        else if (n == 2) pts = 11'(PTS_2);
        else if (n == 3) pts = 11'(PTS_3);
        else if (n >= 4) pts = 11'(PTS_4);
        return pts;
    endfunction

endpackage

// File: rtl/line_clear_engine_if.sv
// Request/result bundle between the piece-lock logic and the line clear engine.
interface line_clear_engine_if
    import tetris_pkg::*;
#(
    parameter int unsigned ROWS    = DEFAULT_ROWS,
    parameter int unsigned COLS    = DEFAULT_COLS,
    parameter int unsigned SCORE_W = 16
) ();

    localparam int unsigned CNT_W = $clog2(ROWS + 1);

    logic                       start;
    logic                       clear_stats;
    logic [ROWS-1:0][COLS-1:0]  board_in;
    logic [ROWS-1:0][COLS-1:0]  board_out;
    logic [ROWS-1:0]            clear_mask;
    logic [CNT_W-1:0]           lines_cleared;
    logic                       busy;
    logic                       done;
    logic [SCORE_W-1:0]         score;
    logic [3:0]                 level;

    modport master (
        output start, clear_stats, board_in,
        input  board_out, clear_mask, lines_cleared, busy, done, score, level
    );

    modport slave (
        input  start, clear_stats, board_in,
        output board_out, clear_mask, lines_cleared, busy, done, score, level
    );

endinterface

// File: rtl/lc_scorer.sv
// Combinational score/level update for one evaluation, with saturation.
module lc_scorer
    import tetris_pkg::*;
#(
    parameter int unsigned N_W         = 5,
    parameter int unsigned SCORE_W     = 16,
    parameter int unsigned CTR_W       = 4,
    parameter int unsigned LEVEL_LINES = 10,
    parameter int unsigned MAX_LEVEL   = 15
) (
    input  logic [N_W-1:0]     n,
    input  logic [3:0]         level,
    input  logic [SCORE_W-1:0] score,
    input  logic [CTR_W-1:0]   level_ctr,
    output logic [SCORE_W-1:0] score_next_c,
    output logic [3:0]         level_next_c,
    output logic [CTR_W-1:0]   level_ctr_next_c
);

    localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);

    logic [31:0] gain_c;
    logic [31:0] sum_c;
    logic [31:0] t_c;
    logic [31:0] rem_c;

    // Points scale with the level held before this evaluation; at most one level step.
    always_comb begin
        gain_c           = 32'(base_points(32'(n))) * (32'(level) + 32'd1);
        sum_c            = 32'(score) + gain_c;
        score_next_c     = (sum_c > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(sum_c);
        t_c              = 32'(level_ctr) + 32'(n);
        rem_c            = 32'd0;
        level_next_c     = level;
        level_ctr_next_c = CTR_W'(t_c);
        if (t_c >= LEVEL_LINES) begin
            rem_c            = t_c - LEVEL_LINES;
            level_next_c     = (32'(level) < MAX_LEVEL) ? level + 4'd1 : 4'(MAX_LEVEL);
            level_ctr_next_c = (rem_c > LEVEL_LINES - 1) ? CTR_W'(LEVEL_LINES - 1)
                                                         : CTR_W'(rem_c);
        end
    end

endmodule

// File: rtl/line_clear_engine.sv
// Whole-board line clear: bottom-up in-place compaction, top fill, then scoring.
module line_clear_engine
    import tetris_pkg::*;
#(
    parameter int unsigned ROWS        = DEFAULT_ROWS,
    parameter int unsigned COLS        = DEFAULT_COLS,
    parameter int unsigned SCORE_W     = 16,
    parameter int unsigned LEVEL_LINES = 10,
    parameter int unsigned MAX_LEVEL   = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    line_clear_engine_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(ROWS + 1);
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned CTR_W = (LEVEL_LINES > 1) ? $clog2(LEVEL_LINES) : 1;

    lc_state_t                  state;
    lc_state_t                  state_next;
    logic [ROWS-1:0][COLS-1:0]  work;
    logic [ROW_W-1:0]           rd_row;
    logic [ROW_W-1:0]           wr_row;
    logic [ROWS-1:0]            clear_mask;
    logic [CNT_W-1:0]           lines_cleared;
    logic [SCORE_W-1:0]         score;
    logic [3:0]                 level;
    logic [CTR_W-1:0]           level_ctr;
    logic                       busy;
    logic                       done;
    logic [COLS-1:0]            rd_data_c;
    logic                       row_full_c;
    logic [SCORE_W-1:0]         score_next_c;
    logic [3:0]                 level_next_c;
    logic [CTR_W-1:0]           level_ctr_next_c;

    assign rd_data_c  = work[rd_row];
    assign row_full_c = &rd_data_c;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state: fixed-length sequence, start only honoured in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SCAN;
            SCAN:    if (rd_row == '0) state_next = FILL;
            FILL:    state_next = SCORE;
            SCORE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered status flags, aligned with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
        end
    end

    // Board datapath: latch, compact (wr_row never passes rd_row), then blank the top.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work          <= '0;
            rd_row        <= '0;
            wr_row        <= '0;
            clear_mask    <= '0;
            lines_cleared <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        work          <= bus.board_in;
                        rd_row        <= ROW_W'(ROWS - 1);
                        wr_row        <= ROW_W'(ROWS - 1);
                        clear_mask    <= '0;
                        lines_cleared <= '0;
                    end
                end
                SCAN: begin
                    if (row_full_c) begin
                        clear_mask[rd_row] <= 1'b1;
                        lines_cleared      <= lines_cleared + CNT_W'(1);
                    end else begin
                        work[wr_row] <= rd_data_c;
                        wr_row       <= wr_row - ROW_W'(1);
                    end
                    if (rd_row != '0) rd_row <= rd_row - ROW_W'(1);
                end
                FILL: begin
                    for (int unsigned r = 0; r < ROWS; r++) begin
                        if (r < 32'(lines_cleared)) work[ROW_W'(r)] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Score/level registers; clear_stats overrides the SCORE-cycle update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score     <= '0;
            level     <= '0;
            level_ctr <= '0;
        end else if (bus.clear_stats) begin
            score     <= '0;
            level     <= '0;
            level_ctr <= '0;
        end else if (state == SCORE) begin
            score     <= score_next_c;
            level     <= level_next_c;
            level_ctr <= level_ctr_next_c;
        end
    end

    lc_scorer #(
        .N_W         (CNT_W),
        .SCORE_W     (SCORE_W),
        .CTR_W       (CTR_W),
        .LEVEL_LINES (LEVEL_LINES),
        .MAX_LEVEL   (MAX_LEVEL)
    ) u_scorer (
        .n                (lines_cleared),
        .level            (level),
        .score            (score),
        .level_ctr        (level_ctr),
        .score_next_c     (score_next_c),
        .level_next_c     (level_next_c),
        .level_ctr_next_c (level_ctr_next_c)
    );

    assign bus.board_out     = work;
    assign bus.clear_mask    = clear_mask;
    assign bus.lines_cleared = lines_cleared;
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.score         = score;
    assign bus.level         = level;

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine with a queue-based reference model.
module tb_line_clear_engine;
    import tetris_pkg::*;

    localparam int unsigned ROWS        = 20;
    localparam int unsigned COLS        = 10;
    localparam int unsigned SCORE_W     = 16;
    localparam int unsigned LEVEL_LINES = 10;
    localparam int unsigned MAX_LEVEL   = 15;
    localparam int unsigned SCORE_MAX   = (1 << SCORE_W) - 1;

    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    line_clear_engine_if #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SCORE_W)) bus ();

    line_clear_engine #(
        .ROWS(ROWS), .COLS(COLS), .SCORE_W(SCORE_W),
        .LEVEL_LINES(LEVEL_LINES), .MAX_LEVEL(MAX_LEVEL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    int unsigned     m_score = 0;
    int unsigned     m_level = 0;
    int unsigned     m_ctr   = 0;
    board_t          exp_board = '0;
    logic [ROWS-1:0] exp_mask = '0;
    int unsigned     exp_lines = 0;
    logic            chk_en = 1'b0;
    logic            exp_busy = 1'b0;
    logic            exp_done = 1'b0;
    logic            exp_final = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compaction, mask and scoring straight from the game rules.
    task automatic model_eval(input board_t b, input bit clr);
        logic [COLS-1:0] kept[$];
        int unsigned n;
        int unsigned base;
        int unsigned t;
        n = 0;
        exp_mask = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (b[r] == {COLS{1'b1}}) begin
                exp_mask[r] = 1'b1;
                n++;
            end else begin
                kept.push_back(b[r]);
            end
        end
        exp_board = '0;
        for (int i = 0; i < kept.size(); i++) exp_board[ROWS - 1 - i] = kept[i];
        exp_lines = n;
        base = (n == 0) ? 0 : (n == 1) ? 40 : (n == 2) ? 100 : (n == 3) ? 300 : 1200;
        if (clr) begin
            m_score = 0;
            m_level = 0;
            m_ctr   = 0;
        end else begin
            m_score = m_score + base * (m_level + 1);
            if (m_score > SCORE_MAX) m_score = SCORE_MAX;
            t = m_ctr + n;
            if (t >= LEVEL_LINES) begin
                if (m_level < MAX_LEVEL) m_level++;
                m_ctr = t - LEVEL_LINES;
                if (m_ctr > LEVEL_LINES - 1) m_ctr = LEVEL_LINES - 1;
            end else begin
                m_ctr = t;
            end
        end
    endtask

    // Per-cycle compare against the model's expected handshake and results.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 256'(bus.busy), 256'(exp_busy));
            check("done", 256'(bus.done), 256'(exp_done));
            if (exp_final) begin
                check("board_out", 256'(bus.board_out), 256'(exp_board));
                check("clear_mask", 256'(bus.clear_mask), 256'(exp_mask));
                check("lines_cleared", 256'(bus.lines_cleared), 256'(exp_lines));
                check("score", 256'(bus.score), 256'(m_score));
                check("level", 256'(bus.level), 256'(m_level));
            end
        end
    end

    // One evaluation; optional stray starts at cycles 5 and ROWS+3, optional clear in SCORE.
    task automatic run_eval(input board_t b, input bit glitch, input bit clr_in_score);
        model_eval(b, clr_in_score);
        bus.board_in = b;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.board_in = '0;
        for (int c = 1; c <= int'(ROWS) + 3; c++) begin
            chk_en          = 1'b1;
            exp_busy        = 1'b1;
            exp_done        = (c == int'(ROWS) + 3);
            exp_final       = exp_done;
            bus.start       = glitch && (c == 5 || c == int'(ROWS) + 3);
            bus.clear_stats = clr_in_score && (c == int'(ROWS) + 2);
            @(posedge clk); #1;
        end
        bus.start       = 1'b0;
        bus.clear_stats = 1'b0;
        exp_busy        = 1'b0;
        exp_done        = 1'b0;
        exp_final       = 1'b1;
        @(posedge clk); #1;
        chk_en    = 1'b0;
        exp_final = 1'b0;
    endtask

    task automatic pulse_clear_stats();
        bus.clear_stats = 1'b1;
        @(posedge clk); #1;
        bus.clear_stats = 1'b0;
        m_score = 0;
        m_level = 0;
        m_ctr   = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 256'(bus.busy), 256'(0));
        check({tag, "_done"}, 256'(bus.done), 256'(0));
        check({tag, "_board"}, 256'(bus.board_out), 256'(0));
        check({tag, "_mask"}, 256'(bus.clear_mask), 256'(0));
        check({tag, "_lines"}, 256'(bus.lines_cleared), 256'(0));
        check({tag, "_score"}, 256'(bus.score), 256'(0));
        check({tag, "_level"}, 256'(bus.level), 256'(0));
    endtask

    board_t b_empty, b_two, b_four, b_full, b_mixed;

    initial begin
        bus.start       = 1'b0;
        bus.clear_stats = 1'b0;
        bus.board_in    = '0;

        b_empty = '0;
        b_two = '0;
        b_two[19] = '1;
        b_two[18] = 10'b1000000001;
        b_two[17] = '1;
        b_two[16] = 10'b0000000011;
        b_four = '0;
        for (int r = 16; r < 20; r++) b_four[r] = '1;
        b_four[15] = 10'b0101010101;
        b_four[3]  = 10'b1100000000;
        b_full = '1;
        for (int r = 0; r < int'(ROWS); r++) b_mixed[r] = COLS'((r * 37 + 11) % 1023);
        b_mixed[0]  = '1;
        b_mixed[5]  = '1;
        b_mixed[12] = '1;
        b_mixed[19] = '1;

        // Reset values
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Empty board
        run_eval(b_empty, 1'b0, 1'b0);
        check("lit_empty_lines", 256'(bus.lines_cleared), 256'(0));
        check("lit_empty_score", 256'(bus.score), 256'(0));

        // Two separated full rows
        run_eval(b_two, 1'b0, 1'b0);
        check("lit_two_mask", 256'(bus.clear_mask), 256'(20'hA0000));
        check("lit_two_lines", 256'(bus.lines_cleared), 256'(2));
        check("lit_two_row19", 256'(bus.board_out[19]), 256'(10'b1000000001));
        check("lit_two_row18", 256'(bus.board_out[18]), 256'(10'b0000000011));
        check("lit_two_score", 256'(bus.score), 256'(100));

        // Three tetrises from zero stats: level steps on the third
        pulse_clear_stats();
        run_eval(b_four, 1'b0, 1'b0);
        check("lit_four_score1", 256'(bus.score), 256'(1200));
        check("lit_four_row19", 256'(bus.board_out[19]), 256'(10'b0101010101));
        check("lit_four_level1", 256'(bus.level), 256'(0));
        run_eval(b_four, 1'b0, 1'b0);
        run_eval(b_four, 1'b0, 1'b0);
        check("lit_four_score3", 256'(bus.score), 256'(3600));
        check("lit_four_level3", 256'(bus.level), 256'(1));

        // Mixed pattern
        run_eval(b_mixed, 1'b0, 1'b0);

        // Full boards: score saturation then level saturation
        pulse_clear_stats();
        for (int k = 0; k < 10; k++) run_eval(b_full, 1'b0, 1'b0);
        check("lit_sat_score", 256'(bus.score), 256'(65535));
        check("lit_full_lines", 256'(bus.lines_cleared), 256'(20));
        check("lit_full_board", 256'(bus.board_out), 256'(0));
        for (int k = 0; k < 7; k++) run_eval(b_full, 1'b0, 1'b0);
        check("lit_max_level", 256'(bus.level), 256'(15));

        // Stray starts ignored; clear_stats in SCORE wins
        run_eval(b_mixed, 1'b1, 1'b1);
        check("lit_clr_score", 256'(bus.score), 256'(0));
        check("lit_clr_level", 256'(bus.level), 256'(0));

        // Build up a nonzero score, then reset mid-SCAN
        run_eval(b_four, 1'b0, 1'b0);
        bus.board_in = b_two;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_score = 0;
        m_level = 0;
        m_ctr   = 0;
        @(posedge clk); #1;
        run_eval(b_two, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
